id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
ID/EX pipeline boundary of the RISC-V core. It buffers decoded instructions (ALUOp, Funct3, Funct7, control bits, operands) from decode and presents them to execute, where the ALU control decoder and ALU consume them. It uses a valid/ready handshake with a 2-entry skid buffer, so an EX stall never creates a combinational ready path back into decode. It also supports flush on branch/jump redirect and counts EX bubble cycles.

Parameters:
DATA_W, 32, width of PC, rs1 data, rs2 data and immediate
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  clock (all state updates on rising edge)
rst_n  input  1  asynchronous active-low reset
flush  input  1  kill all buffered entries (branch/jump redirect)
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept; equals NOT skid_v, driven from a flop only
in_alu_op  input  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
in_funct3  input  3  instr[14:12]
in_funct7  input  7  instr[31:25]
in_ctrl  input  7  {Jump, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite}
in_data  input  4*DATA_W  {pc, rd1, rd2, imm}
in_regs  input  3*REG_ADDR_W  {rs1, rs2, rd}
out_valid  output  1  EX holds a valid instruction
out_ready  input  1  EX consumes the instruction this cycle
out_alu_op, out_funct3, out_funct7, out_ctrl, out_data, out_regs  output  same widths as in_*  registered payload to EX
bubble_cnt  output  16  saturating count of EX bubble cycles

Behaviour:
- Reset (async, rst_n=0): main_v=0, skid_v=0, all payload registers 0, out_valid=0, in_ready=1, bubble_cnt=0. Reset mid-transfer drops both entries without completing either handshake.
- acc = in_valid & in_ready; drn = out_valid & out_ready.
- out_* always reflect the main register. out_valid=main_v. Latency from in to out is 1 cycle when empty.
- State machine on {main_v, skid_v}:
  - EMPTY (0,0): acc -> main<=in, go FULL.
  - FULL (1,0):
    - drn&acc -> main<=in, stay FULL.
    - drn&!acc -> EMPTY.
    - !drn&acc -> skid<=in, go SKID.
    - Neither -> hold.
  - SKID (1,1): in_ready=0. drn -> main<=skid, skid_v=0, go FULL. Otherwise hold.
  - (0,1) is illegal and unreachable. If reached, it recovers to EMPTY next cycle.
- Ordering is strictly FIFO. No entry is lost or duplicated without flush.
- Flush has priority over everything:
  - Next state is EMPTY.
  - Any same-cycle acc is dropped. Decode sees the acceptance, but the instruction is discarded.
  - A same-cycle drn completes normally; EX has already sampled it.
  - in_ready=1 the following cycle.
- Bubble gating: when out_valid=0, out_ctrl is forced to 0 and out_alu_op to 00. This prevents spurious RegWrite/MemWrite/Branch. out_funct*, out_data and out_regs hold their last value.
- Payload flops update only on load. Otherwise they hold (no toggling while stalled).
- bubble_cnt increments when out_ready=1 and out_valid=0. It saturates at 16'hFFFF. It is cleared only by reset; flush does not clear it.

Test Plan:
- Reset release, then in_valid=1 with alu_op=10, funct3=000, funct7=0100000 (sub), out_ready=1 -> next cycle out_valid=1 with identical payload, in_ready stays 1.
- Back-to-back stream of 4 instructions with out_ready=1 -> emitted in order at 1/cycle, no gaps, bubble_cnt unchanged.
- Hold out_ready=0 while sending A, B, C -> A in main, B in skid, in_ready=0 from cycle after B, C held by decode. Release out_ready -> A, B, C emitted in order.
- SKID state plus flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, out_ctrl=0, out_alu_op=00, and the flushed-cycle input is never emitted.
- Idle with out_ready=1 for 70000 cycles -> bubble_cnt saturates at 65535 and does not wrap.
- Assert rst_n=0 asynchronously mid-cycle while in SKID -> out_valid=0 and in_ready=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with 2-entry skid buffer, flush and bubble counter
module id_ex_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_alu_op,
  input  logic [2:0]              in_funct3,
  input  logic [6:0]              in_funct7,
  input  logic [6:0]              in_ctrl,
  input  logic [4*DATA_W-1:0]     in_data,
  input  logic [3*REG_ADDR_W-1:0] in_regs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_alu_op,
  output logic [2:0]              out_funct3,
  output logic [6:0]              out_funct7,
  output logic [6:0]              out_ctrl,
  output logic [4*DATA_W-1:0]     out_data,
  output logic [3*REG_ADDR_W-1:0] out_regs,
  output logic [15:0]             bubble_cnt
);
  localparam int PW = 19 + 4*DATA_W + 3*REG_ADDR_W;
  typedef enum logic [1:0] {EMPTY = 2'b00, BAD = 2'b01, FULL = 2'b10, SKID = 2'b11} state_t;
  state_t state, state_n;
  logic [PW-1:0] main_q, skid_q, in_p;
  logic main_v, skid_v, acc, drn, ld_in, ld_skid, ld_fwd;
  assign main_v    = state[1];
  assign skid_v    = state[0];
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign in_p      = {in_alu_op, in_funct3, in_funct7, in_ctrl, in_data, in_regs};
  assign acc       = in_valid & in_ready;
  assign drn       = main_v & out_ready;
  always_comb begin
    state_n = state;
    ld_in   = 1'b0;
    ld_skid = 1'b0;
    ld_fwd  = 1'b0;
    case (state)
      EMPTY: begin
        state_n = acc ? FULL : EMPTY;
        ld_in   = acc;
      end
      FULL: begin
        state_n = drn ? (acc ? FULL : EMPTY) : (acc ? SKID : FULL);
        ld_in   = acc & drn;
        ld_skid = acc & ~drn;
      end
      SKID: begin
        state_n = drn ? FULL : SKID;
        ld_fwd  = drn;
      end
      default: state_n = EMPTY;
    endcase
    // flush wins: a same-cycle acceptance is discarded, a same-cycle drain already happened
    if (flush) begin
      state_n = EMPTY;
      ld_in   = 1'b0;
      ld_skid = 1'b0;
      ld_fwd  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) main_q <= '0;
    else if (ld_in) main_q <= in_p;
    else if (ld_fwd) main_q <= skid_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) skid_q <= '0;
    else if (ld_skid) skid_q <= in_p;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bubble_cnt <= '0;
    else if (out_ready & ~main_v & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 16'd1;
  // control fields are gated so a bubble can never write registers or memory
  assign out_alu_op = main_v ? main_q[PW-1 -: 2] : 2'b00;
  assign out_funct3 = main_q[PW-3 -: 3];
  assign out_funct7 = main_q[PW-6 -: 7];
  assign out_ctrl   = main_v ? main_q[PW-13 -: 7] : 7'd0;
  assign out_data   = main_q[3*REG_ADDR_W +: 4*DATA_W];
  assign out_regs   = main_q[3*REG_ADDR_W-1:0];
endmodule
